argmax_classifier: RTL and testbench

ARGMAX_CLASSIFIER -- requirements
Module: argmax_classifier

---
 rtl/argmax_classifier_if.sv | 29 ++
 rtl/argmax_classifier.sv | 128 ++++++++++++
 tb/tb_argmax_classifier.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/argmax_classifier_if.sv
// rtl/argmax_classifier_if.sv - probability-in / class-out handshake bundle for argmax_classifier
interface argmax_classifier_if;
    logic              valid_in;
    logic [9:0][31:0]  prob_in;
    logic              ready_out;
    logic [3:0]        class_idx;
    logic [31:0]       class_prob;
`ifdef CONF_THRESH_EN
    logic              low_conf;
`endif
    logic              valid_out;
    logic              ready_in;

    modport master (
        output valid_in, prob_in, ready_in,
`ifdef CONF_THRESH_EN
        input  low_conf,
`endif
        input  ready_out, class_idx, class_prob, valid_out
    );

    modport slave (
        input  valid_in, prob_in, ready_in,
`ifdef CONF_THRESH_EN
        output low_conf,
`endif
        output ready_out, class_idx, class_prob, valid_out
    );
endinterface

// File: rtl/argmax_classifier.sv
// rtl/argmax_classifier.sv - sequential argmax over ten IEEE-754 probabilities (optional CONF_THRESH_EN low-confidence flag)
module argmax_classifier #(
    parameter logic [31:0] THRESH = 32'h3F000000
) (
    input  logic              clk,
    input  logic              resetn,
    argmax_classifier_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SCAN, HOLD} state_t;

    state_t            state_q, state_d;
    logic [9:0][31:0]  prob_buf;
    logic [31:0]       best_q;
    logic [3:0]        best_idx_q;
    logic [3:0]        cnt_q;
    logic              valid_q;
    logic [3:0]        class_idx_q;
    logic [31:0]       class_prob_q;

    logic [31:0]       cand;
    logic              take;
    logic [31:0]       best_n;
    logic [3:0]        idx_n;

    // Total order: NaN lowest, zeros of either sign equal, negatives by reversed magnitude.
    function automatic logic rank_gt(input logic [31:0] a, input logic [31:0] b);
        logic a_nan, b_nan, a_neg, b_neg;
        a_nan = (&a[30:23]) && (|a[22:0]);
        b_nan = (&b[30:23]) && (|b[22:0]);
        a_neg = a[31] && (|a[30:0]);
        b_neg = b[31] && (|b[30:0]);
        if (a_nan)
            rank_gt = 1'b0;
        else if (b_nan)
            rank_gt = 1'b1;
        else if (a_neg != b_neg)
            rank_gt = b_neg;
        else if (a_neg)
            rank_gt = a[30:0] < b[30:0];
        else
            rank_gt = a[30:0] > b[30:0];
    endfunction

    assign cand   = prob_buf[cnt_q];
    assign take   = rank_gt(cand, best_q);
    assign best_n = take ? cand  : best_q;
    assign idx_n  = take ? cnt_q : best_idx_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.valid_in)     state_d = SCAN;
            SCAN:    if (cnt_q == 4'd9)    state_d = HOLD;
            HOLD:    if (bus.ready_in)     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Buffer carries no reset: its contents only matter after a capture.
    always_ff @(posedge clk) begin
        if (state_q == IDLE && bus.valid_in)
            prob_buf <= bus.prob_in;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            best_q       <= '0;
            best_idx_q   <= '0;
            cnt_q        <= '0;
            valid_q      <= 1'b0;
            class_idx_q  <= '0;
            class_prob_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.valid_in) begin
                        best_q     <= bus.prob_in[0];
                        best_idx_q <= 4'd0;
                        cnt_q      <= 4'd1;
                    end
                end
                SCAN: begin
                    best_q     <= best_n;
                    best_idx_q <= idx_n;
                    cnt_q      <= cnt_q + 4'd1;
                    if (cnt_q == 4'd9) begin
                        class_idx_q  <= idx_n;
                        class_prob_q <= best_n;
                        valid_q      <= 1'b1;
                    end
                end
                HOLD: begin
                    if (bus.ready_in)
                        valid_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

`ifdef CONF_THRESH_EN
    logic low_conf_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            low_conf_q <= 1'b0;
        else if (state_q == SCAN && cnt_q == 4'd9)
            low_conf_q <= rank_gt(THRESH, best_n);
    end

    assign bus.low_conf = low_conf_q;
`else
    logic unused_thresh;
    assign unused_thresh = ^THRESH;
`endif

    assign bus.ready_out  = (state_q == IDLE);
    assign bus.valid_out  = valid_q;
    assign bus.class_idx  = class_idx_q;
    assign bus.class_prob = class_prob_q;
endmodule

// File: tb/tb_argmax_classifier.sv
// tb/tb_argmax_classifier.sv - scoreboard bench for argmax_classifier against a rank-key reference model
module tb_argmax_classifier;
    localparam logic [31:0] THRESH = 32'h3F000000;

    typedef struct packed {
        logic [3:0]  idx;
        logic [31:0] prob;
        logic        low;
    } exp_t;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    argmax_classifier_if bus ();

    argmax_classifier #(.THRESH(THRESH)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Order-preserving integer key: NaN below everything, -x mapped to negative magnitude.
    function automatic longint rank_key(input logic [31:0] w);
        longint mag;
        mag = longint'({33'd0, w[30:0]});
        if (w[30:23] == 8'hFF && w[22:0] != 23'd0)
            return -longint'(64'd4294967296);
        return w[31] ? -mag : mag;
    endfunction

    function automatic exp_t model(input logic [9:0][31:0] p);
        exp_t e;
        int   bi;
        bi = 0;
        for (int i = 1; i < 10; i++)
            if (rank_key(p[i]) > rank_key(p[bi])) bi = i;
        e.idx  = 4'(bi);
        e.prob = p[bi];
        e.low  = (rank_key(p[bi]) < rank_key(THRESH));
        return e;
    endfunction

    function automatic logic [31:0] rand_word();
        logic [31:0] specials [8];
        specials = '{32'h7FC00000, 32'hFFC00001, 32'h7F800000, 32'hFF800000,
                     32'h00000000, 32'h80000000, 32'h3F800000, 32'hBF800000};
        case ($urandom_range(0, 3))
            0:       return specials[$urandom_range(0, 7)];
            1:       return $urandom();
            default: return {2'b00, 30'($urandom())};
        endcase
    endfunction

    function automatic logic low_conf_now();
`ifdef CONF_THRESH_EN
        return bus.low_conf;
`else
        return 1'b0;
`endif
    endfunction

    always @(negedge clk) begin
        if (resetn && bus.valid_out && bus.ready_in) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got idx %0d with empty scoreboard, expected none", bus.class_idx);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("class_idx", 32'(bus.class_idx), 32'(e.idx));
                check("class_prob", bus.class_prob, e.prob);
`ifdef CONF_THRESH_EN
                check("low_conf", 32'(bus.low_conf), 32'(e.low));
`endif
            end
        end
    end

    task automatic wait_ready();
        int n;
        n = 0;
        while (!bus.ready_out && n < 50) begin
            @(posedge clk); #1; n++;
        end
        check("ready_wait_timeout", 32'(bus.ready_out), 32'd1);
    endtask

    task automatic txn(input logic [9:0][31:0] p, input int hold, input bit inject);
        int          n;
        logic [3:0]  s_idx;
        logic [31:0] s_prob;
        logic        s_low;
        wait_ready();
        bus.prob_in  = p;
        bus.valid_in = 1'b1;
        bus.ready_in = 1'b0;
        @(posedge clk); #1;
        exp_q.push_back(model(p));
        bus.valid_in = 1'b0;
        for (int i = 0; i < 10; i++) bus.prob_in[i] = $urandom();
        check("ready_low_after_accept", 32'(bus.ready_out), 32'd0);
        n = 0;
        while (!bus.valid_out && n < 20) begin
            @(posedge clk); #1; n++;
        end
        check("latency_edges", 32'(n), 32'd9);
        s_idx  = bus.class_idx;
        s_prob = bus.class_prob;
        s_low  = low_conf_now();
        for (int i = 0; i < hold; i++) begin
            bus.valid_in = inject && (i == hold / 2);
            @(posedge clk); #1;
            bus.valid_in = 1'b0;
            check("hold_valid", 32'(bus.valid_out), 32'd1);
            check("hold_stable", {bus.class_idx, 1'b0, low_conf_now()} ^ 32'(bus.class_prob != s_prob),
                  {s_idx, 1'b0, s_low});
        end
        bus.ready_in = 1'b1;
        @(posedge clk); #1;
        bus.ready_in = 1'b0;
        check("idle_ready_after_accept", 32'(bus.ready_out), 32'd1);
        check("valid_dropped", 32'(bus.valid_out), 32'd0);
    endtask

    initial begin
        logic [9:0][31:0] p;
        int               n;
        bus.valid_in = 1'b0;
        bus.ready_in = 1'b0;
        bus.prob_in  = '0;
        #12;
        check("rst_ready_out", 32'(bus.ready_out), 32'd1);
        check("rst_valid_out", 32'(bus.valid_out), 32'd0);
        check("rst_class_idx", 32'(bus.class_idx), 32'd0);
        check("rst_class_prob", bus.class_prob, 32'd0);
        @(posedge clk); #1;
        resetn = 1'b1;

        for (int i = 0; i < 10; i++) p[i] = 32'h3D4CCCCD;
        p[6] = 32'h3F0CCCCD;
        txn(p, 0, 1'b0);

        for (int i = 0; i < 10; i++) p[i] = 32'h3CCCCCCD;
        p[2] = 32'h3ECCCCCD;
        p[7] = 32'h3ECCCCCD;
        txn(p, 5, 1'b1);

        for (int i = 0; i < 10; i++) p[i] = 32'hBF000000;
        p[0] = 32'h7FC00000;
        p[3] = 32'hBF800000;
        p[5] = 32'h00000000;
        txn(p, 2, 1'b0);

        for (int i = 0; i < 10; i++) p[i] = 32'h3DCCCCCD;
        txn(p, 0, 1'b0);

        for (int i = 0; i < 10; i++) p[i] = 32'h7FC00000 + 32'(i);
        txn(p, 1, 1'b0);

        // Abort mid-scan: result must never appear.
        for (int i = 0; i < 10; i++) p[i] = 32'(i);
        wait_ready();
        bus.prob_in  = p;
        bus.valid_in = 1'b1;
        @(posedge clk); #1;
        bus.valid_in = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        resetn = 1'b0;
        #1;
        check("abort_valid_out", 32'(bus.valid_out), 32'd0);
        check("abort_class_idx", 32'(bus.class_idx), 32'd0);
        check("abort_class_prob", bus.class_prob, 32'd0);
        check("abort_ready_out", 32'(bus.ready_out), 32'd1);
        @(posedge clk); #1;
        resetn = 1'b1;
        n = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (bus.valid_out) n++;
        end
        check("abort_no_valid_pulse", 32'(n), 32'd0);
        p[4] = 32'h3F800000;
        txn(p, 0, 1'b0);

        for (int t = 0; t < 30; t++) begin
            for (int i = 0; i < 10; i++) p[i] = rand_word();
            if ($urandom_range(0, 2) == 0) p[$urandom_range(5, 9)] = p[$urandom_range(0, 4)];
            txn(p, $urandom_range(0, 3), $urandom_range(0, 1) == 1);
        end

        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(posedge clk); n++;
        end
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
